// File: rtl/io_port_ctrl.sv
// CPU bus port controller: manual switch drive, NPORT output port registers and an input FIFO.
// Optional macro IO_READBACK_EN adds port-register readback on rsel=10.
module io_port_ctrl #(
  parameter int DW     = 8,
  parameter int NPORT  = 4,
  parameter int FDEPTH = 4
) (
  input  logic                                         clk,
  input  logic                                         nrst,
  inout  wire logic [DW-1:0]                           bus,
  input  logic                                         nsw_bus,
  input  logic                                         ce,
  input  logic                                         we,
  input  logic                                         re,
  input  logic                                         load,
  input  logic [((NPORT > 1) ? $clog2(NPORT) : 1)-1:0] port_sel,
  input  logic [1:0]                                   rsel,
  input  logic [DW-1:0]                                sw_addr,
  input  logic [DW-1:0]                                sw_data,
  output logic [NPORT*DW-1:0]                          port_out,
  input  logic [DW-1:0]                                in_data,
  input  logic                                         in_valid,
  output logic                                         in_ready
);

  localparam int AW = $clog2(FDEPTH);
  localparam int CW = $clog2(FDEPTH) + 1;
  localparam int SW = 3 + CW;

  logic [DW-1:0]    ports [NPORT];
  logic [DW-1:0]    mem   [FDEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             underflow;
  logic             empty, full;
  logic             cpu_rd, cpu_wr, sel_ok;
  logic             push, pop, uf_evt, stat_rd;
  logic [SW-1:0]    stat_raw;
  logic [SW+DW-1:0] stat_ext;
  logic [DW-1:0]    status, rd_data;
  logic             drive_en;
  logic [DW-1:0]    drive_val;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FDEPTH));
  assign in_ready = ~full;

  // CPU access only outside manual mode; we and re together cancel both.
  assign cpu_rd  = nsw_bus & ~ce & re & ~we;
  assign cpu_wr  = nsw_bus & ~ce & we & ~re;
  assign sel_ok  = (32'(port_sel) < NPORT);

  assign push    = in_valid & ~full;
  assign pop     = cpu_rd & (rsel == 2'b00) & ~empty;
  assign uf_evt  = cpu_rd & (rsel == 2'b00) & empty;
  assign stat_rd = cpu_rd & (rsel == 2'b01);

  // Status fields are zero-extended, or truncated when DW is narrower.
  assign stat_raw = {count, underflow, full, empty};
  assign stat_ext = {{DW{1'b0}}, stat_raw};
  assign status   = stat_ext[DW-1:0];

  always_comb begin
    rd_data = '0;
    case (rsel)
      2'b00:   if (!empty) rd_data = mem[rd_ptr];
      2'b01:   rd_data = status;
`ifdef IO_READBACK_EN
      2'b10:   if (sel_ok) rd_data = ports[port_sel];
`else
      2'b10:   rd_data = '0;
`endif
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    drive_en  = 1'b0;
    drive_val = '0;
    if (!nsw_bus) begin
      if (load) begin
        drive_en  = 1'b1;
        drive_val = sw_addr;
      end else if (!ce && !we) begin
        drive_en  = 1'b1;
        drive_val = sw_data;
      end
    end else if (cpu_rd) begin
      drive_en  = 1'b1;
      drive_val = rd_data;
    end
  end

  assign bus = drive_en ? drive_val : 'z;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned k = 0; k < NPORT; k++) ports[k] <= '0;
    end else if (cpu_wr && sel_ok) begin
      ports[port_sel] <= bus;
    end
  end

  always_comb begin
    port_out = '0;
    for (int unsigned k = 0; k < NPORT; k++) port_out[k*DW +: DW] = ports[k];
  end

  always_ff @(posedge clk) begin
    if (push && nrst) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new underflow outranks the clear-on-status-read.
      if (uf_evt)       underflow <= 1'b1;
      else if (stat_rd) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl (DW=8, NPORT=4, FDEPTH=4) with hand-computed expectations.
module tb_io_port_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  wire  [7:0]  bus;
  logic [7:0]  bus_drv;
  logic        bus_oe;
  logic        nsw_bus, ce, we, re, load;
  logic [1:0]  port_sel;
  logic [1:0]  rsel;
  logic [7:0]  sw_addr, sw_data;
  logic [31:0] port_out;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  assign bus = bus_oe ? bus_drv : 'z;

  always #5 clk = ~clk;

  io_port_ctrl #(.DW(8), .NPORT(4), .FDEPTH(4)) dut (
    .clk(clk), .nrst(nrst), .bus(bus), .nsw_bus(nsw_bus), .ce(ce), .we(we),
    .re(re), .load(load), .port_sel(port_sel), .rsel(rsel), .sw_addr(sw_addr),
    .sw_data(sw_data), .port_out(port_out), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce = 1'b1; we = 1'b0; re = 1'b0; load = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic port_write(input logic [1:0] sel, input logic [7:0] val);
    nsw_bus = 1'b1; ce = 1'b0; we = 1'b1; re = 1'b0;
    port_sel = sel; bus_drv = val; bus_oe = 1'b1;
    tick();
    idle();
  endtask

  task automatic push(input logic [7:0] val);
    in_valid = 1'b1; in_data = val;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read_status(input string tag, input logic [7:0] exp);
    nsw_bus = 1'b1; ce = 1'b0; re = 1'b0; we = 1'b0; re = 1'b1; rsel = 2'b01;
    #1;
    chk(tag, {24'd0, bus}, {24'd0, exp});
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b0; nsw_bus = 1'b1; port_sel = '0; rsel = '0;
    sw_addr = '0; sw_data = '0; in_data = '0; in_valid = 1'b0; bus_drv = '0;
    idle();
    #1;
    chk("rst_port_out", port_out, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    read_status("status_after_reset", 8'h01);

    // Manual switch mode
    nsw_bus = 1'b0; load = 1'b1; sw_addr = 8'h3C;
    #1 chk("manual_addr", {24'd0, bus}, 32'h3C);
    load = 1'b0; ce = 1'b0; we = 1'b0; sw_data = 8'hA5;
    #1 chk("manual_data", {24'd0, bus}, 32'hA5);
    // Manual mode suppresses CPU writes
    we = 1'b1; port_sel = 2'd0; bus_drv = 8'h99; bus_oe = 1'b1;
    tick();
    idle();
    chk("manual_blocks_write", port_out, 32'h0);
    nsw_bus = 1'b1;

    // Port writes
    port_write(2'd2, 8'h5A);
    chk("port2_write", port_out, 32'h005A_0000);
    port_write(2'd1, 8'hC3);
    chk("port1_write", port_out, 32'h005A_C300);
    ce = 1'b0; we = 1'b1; re = 1'b1; port_sel = 2'd3; bus_drv = 8'hFF; bus_oe = 1'b1;
    tick();
    idle();
    chk("we_re_no_write", port_out, 32'h005A_C300);

    // Readback and reserved source
    ce = 1'b0; re = 1'b1; rsel = 2'b10; port_sel = 2'd1;
    #1;
`ifdef IO_READBACK_EN
    chk("readback_p1", {24'd0, bus}, 32'hC3);
`else
    chk("readback_p1", {24'd0, bus}, 32'h00);
`endif
    rsel = 2'b11;
    #1 chk("rsel_reserved", {24'd0, bus}, 32'h00);
    idle();

    // FIFO fill
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("full_in_ready", {31'd0, in_ready}, 32'h0);
    in_valid = 1'b1; in_data = 8'h55;
    read_status("status_full", 8'h22);
    in_valid = 1'b0;
    read_status("status_full_after_5th", 8'h22);
    ce = 1'b0; re = 1'b1; rsel = 2'b00;
    #1 chk("pop_11", {24'd0, bus}, 32'h11);
    tick(); chk("pop_22", {24'd0, bus}, 32'h22);
    tick(); chk("pop_33", {24'd0, bus}, 32'h33);
    tick(); chk("pop_44", {24'd0, bus}, 32'h44);
    tick();
    idle();
    read_status("status_drained", 8'h01);

    // Underflow, then clear on status read
    ce = 1'b0; re = 1'b1; rsel = 2'b00;
    #1 chk("underflow_bus", {24'd0, bus}, 32'h00);
    tick();
    idle();
    read_status("status_underflow", 8'h05);
    read_status("status_uf_cleared", 8'h01);

    // Simultaneous push and pop at count 2
    push(8'hAA); push(8'hBB);
    in_valid = 1'b1; in_data = 8'h77; ce = 1'b0; re = 1'b1; rsel = 2'b00;
    #1 chk("simul_head", {24'd0, bus}, 32'hAA);
    tick();
    in_valid = 1'b0;
    idle();
    read_status("simul_count2", 8'h10);
    ce = 1'b0; re = 1'b1; rsel = 2'b00;
    #1 chk("simul_next_bb", {24'd0, bus}, 32'hBB);
    tick(); chk("simul_tail_77", {24'd0, bus}, 32'h77);
    tick();
    idle();

    // Reset mid-operation
    push(8'h01); push(8'h02); push(8'h03);
    read_status("status_count3", 8'h18);
    in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("midrst_port_out", port_out, 32'h0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'h1);
    tick();
    @(negedge clk);
    nrst = 1'b1;
    in_valid = 1'b0;
    #1;
    read_status("status_after_midrst", 8'h01);

    port_write(2'd1, 8'hC3);
    ce = 1'b0; re = 1'b1; rsel = 2'b10; port_sel = 2'd1;
    #1;
`ifdef IO_READBACK_EN
    chk("readback_after_rst", {24'd0, bus}, 32'hC3);
`else
    chk("readback_after_rst", {24'd0, bus}, 32'h00);
`endif
    idle();

    // Push into empty FIFO while popping: push kept, pop is underflow
    in_valid = 1'b1; in_data = 8'h66; ce = 1'b0; re = 1'b1; rsel = 2'b00;
    #1 chk("empty_push_pop_bus", {24'd0, bus}, 32'h00);
    tick();
    in_valid = 1'b0;
    idle();
    read_status("status_push_uf", 8'h0C);

    // Manual mode suppresses FIFO pop
    nsw_bus = 1'b0; ce = 1'b0; we = 1'b0; re = 1'b1; rsel = 2'b00; sw_data = 8'h5C;
    #1 chk("manual_over_read", {24'd0, bus}, 32'h5C);
    tick();
    idle();
    nsw_bus = 1'b1;
    ce = 1'b0; re = 1'b1; rsel = 2'b00;
    #1 chk("head_kept_66", {24'd0, bus}, 32'h66);
    tick();
    idle();
    read_status("status_final", 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
